fsm_cmd_sequencer: RTL and testbench

- Initiator-side driver for fsm_dut.
- Accepts one data word per request on a valid/ready port and drives fsm_dut's enable/input_signal/data_in through the full command walk IDLE→PROCESS→WAIT→COMPLETE→IDLE.
- Watches fsm_dut's state and status outputs, captures its data_out, and returns the result with an error flag on a valid/ready response port.
- Replaces hand-timed testbench stimulus; usable as synthesizable traffic source in system tests.

---
 rtl/fsm_cmd_sequencer_pkg.sv | 24 ++
 rtl/fsm_cmd_sequencer_if.sv | 23 ++
 rtl/fsm_cmd_sequencer_watchdog.sv | 28 ++
 rtl/fsm_cmd_sequencer.sv | 129 ++++++++++++
 tb/tb_fsm_cmd_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_cmd_sequencer_pkg.sv
// Shared encodings for the fsm_dut command sequencer: commands driven to
// fsm_dut, fsm_dut state codes, and the sequencer's own phase enum.
package fsm_seq_pkg;

   localparam logic [1:0] CMD_IDLE     = 2'b00;
   localparam logic [1:0] CMD_START    = 2'b01;
   localparam logic [1:0] CMD_WAIT     = 2'b10;
   localparam logic [1:0] CMD_COMPLETE = 2'b11;

   localparam logic [1:0] ST_IDLE     = 2'b00;
   localparam logic [1:0] ST_PROCESS  = 2'b01;
   localparam logic [1:0] ST_WAIT     = 2'b10;
   localparam logic [1:0] ST_COMPLETE = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_COMPLETE,
      S_RETURN,
      S_RESP
   } seq_state_t;

endpackage

// File: rtl/fsm_cmd_sequencer_if.sv
// Request/response valid-ready bundle between a traffic consumer (master)
// and the command sequencer (slave).
interface fsm_cmd_sequencer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic [DATA_WIDTH-1:0] req_data;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  rsp_error;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_error
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_error
   );
endinterface

// File: rtl/fsm_cmd_sequencer_watchdog.sv
// Per-phase timeout: a down-counter reloaded on phase entry; expires when it
// reaches terminal count while the phase target is still unmet.
module fsm_seq_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic met,
   output logic expired
);
   localparam int            CW      = $clog2(TIMEOUT);
   localparam logic [CW-1:0] TC_LOAD = CW'(TIMEOUT - 1);

   logic [CW-1:0] remain;

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         remain <= TC_LOAD;
      end else if (!met && remain != '0) begin
         remain <= remain - CW'(1);
      end
   end

   // a target met on the terminal cycle wins over the timeout
   assign expired = (remain == '0) && !met;

endmodule

// File: rtl/fsm_cmd_sequencer.sv
// Initiator-side driver for fsm_dut: walks one request word through the
// START/WAIT/COMPLETE/RETURN command sequence and reports the captured result.
//
// state      | meaning
// S_IDLE     | req_ready high, waiting for a request word
// S_START    | enable + CMD_START, waiting for fsm_dut PROCESS
// S_WAIT     | CMD_WAIT, waiting for fsm_dut WAIT
// S_COMPLETE | CMD_COMPLETE, waiting for COMPLETE with valid; captures data_out
// S_RETURN   | CMD_IDLE, waiting for IDLE with done
// S_RESP     | response held on rsp_* until consumer accepts
module fsm_cmd_sequencer
   import fsm_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   fsm_cmd_sequencer_if.slave    bus,
   output logic                  fsm_enable,
   output logic [1:0]            fsm_input,
   output logic [DATA_WIDTH-1:0] fsm_data,
   input  logic [1:0]            fsm_state,
   input  logic [DATA_WIDTH-1:0] fsm_data_out,
   input  logic                  fsm_valid,
   input  logic                  fsm_done,
   output logic [7:0]            err_count
);

   seq_state_t            state;
   logic [DATA_WIDTH-1:0] req_word;
   logic                  met;
   logic                  in_phase;
   logic                  expired;
   logic                  phase_timeout;

   always_comb begin
      met = 1'b0;
      case (state)
         S_START:    met = (fsm_state == ST_PROCESS);
         S_WAIT:     met = (fsm_state == ST_WAIT);
         S_COMPLETE: met = (fsm_state == ST_COMPLETE) && fsm_valid;
         S_RETURN:   met = (fsm_state == ST_IDLE) && fsm_done;
         default:    met = 1'b0;
      endcase
   end

   assign in_phase      = state inside {S_START, S_WAIT, S_COMPLETE, S_RETURN};
   // the counter still sits at terminal count on the first S_RESP cycle
   assign phase_timeout = in_phase && expired;

   fsm_seq_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (!in_phase || met),
      .met    (met),
      .expired(expired)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         req_word      <= '0;
         bus.req_ready <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_error <= 1'b0;
         fsm_enable    <= 1'b0;
         fsm_input     <= CMD_IDLE;
         fsm_data      <= '0;
         err_count     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               bus.req_ready <= 1'b1;
               if (bus.req_valid && bus.req_ready) begin
                  req_word      <= bus.req_data;
                  fsm_data      <= bus.req_data;
                  bus.req_ready <= 1'b0;
                  fsm_enable    <= 1'b1;
                  fsm_input     <= CMD_START;
                  state         <= S_START;
               end
            end
            S_START: if (met) begin
               fsm_input <= CMD_WAIT;
               state     <= S_WAIT;
            end
            S_WAIT: if (met) begin
               fsm_input <= CMD_COMPLETE;
               state     <= S_COMPLETE;
            end
            S_COMPLETE: if (met) begin
               // result is staged now; it is only presented once rsp_valid rises
               bus.rsp_data  <= fsm_data_out;
               bus.rsp_error <= (fsm_data_out != req_word);
               fsm_input     <= CMD_IDLE;
               state         <= S_RETURN;
            end
            S_RETURN: if (met) begin
               fsm_enable    <= 1'b0;
               bus.rsp_valid <= 1'b1;
               state         <= S_RESP;
            end
            S_RESP: if (bus.rsp_ready) begin
               bus.rsp_valid <= 1'b0;
               bus.req_ready <= 1'b1;
               if (bus.rsp_error && err_count != 8'hFF) begin
                  err_count <= err_count + 8'd1;
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         if (phase_timeout) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_error <= 1'b1;
            bus.rsp_data  <= '0;
            fsm_enable    <= 1'b0;
            fsm_input     <= CMD_IDLE;
            state         <= S_RESP;
         end
      end
   end

endmodule

// File: tb/tb_fsm_cmd_sequencer.sv
// Directed bench for fsm_cmd_sequencer against a small behavioural fsm_dut
// responder with state masking (timeouts) and data corruption (mismatches).
module tb_fsm_cmd_sequencer;
   import fsm_seq_pkg::*;

   localparam int DW = 8;
   localparam int TO = 16;

   typedef struct {
      logic [DW-1:0] req;
      logic          corrupt;
      int            mask_cyc;
      int            exp_lat;
      logic [DW-1:0] exp_data;
      logic          exp_err;
   } vec_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   fsm_cmd_sequencer_if #(.DATA_WIDTH(DW)) bus ();

   logic          fsm_enable;
   logic [1:0]    fsm_input;
   logic [DW-1:0] fsm_data;
   logic [1:0]    fsm_state;
   logic [1:0]    m_state      = 2'b00;
   logic [DW-1:0] fsm_data_out = '0;
   logic          fsm_valid    = 1'b0;
   logic          fsm_done     = 1'b0;
   logic [7:0]    err_count;
   logic          mask_state   = 1'b0;
   logic          corrupt      = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_ec   = 0;

   fsm_cmd_sequencer #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus),
      .fsm_enable  (fsm_enable),
      .fsm_input   (fsm_input),
      .fsm_data    (fsm_data),
      .fsm_state   (fsm_state),
      .fsm_data_out(fsm_data_out),
      .fsm_valid   (fsm_valid),
      .fsm_done    (fsm_done),
      .err_count   (err_count)
   );

   // behavioural fsm_dut: follows the command one cycle later while enabled
   always @(posedge clk) begin
      if (fsm_enable) begin
         m_state   <= fsm_input;
         fsm_valid <= (fsm_input == CMD_COMPLETE);
         fsm_done  <= (m_state == ST_COMPLETE) && (fsm_input == CMD_IDLE);
         if (fsm_input == CMD_COMPLETE) fsm_data_out <= corrupt ? ~fsm_data : fsm_data;
      end else begin
         m_state   <= ST_IDLE;
         fsm_valid <= 1'b0;
         fsm_done  <= 1'b0;
      end
   end

   assign fsm_state = mask_state ? ST_IDLE : m_state;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // returns at #1 after the accepting edge (cycle 0 of S_START)
   task automatic send(input logic [DW-1:0] d);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_data  = d;
      while (!bus.req_ready && n < 50) begin
         step();
         n++;
      end
      check("req_accept_bound", 32'(n < 50), 32'd1);
      step();
      bus.req_valid = 1'b0;
      bus.req_data  = '0;
   endtask

   task automatic run_txn(input vec_t v, input string tag);
      int cyc = 0;
      corrupt    = v.corrupt;
      mask_state = (v.mask_cyc > 0);
      send(v.req);
      forever begin
         if (cyc >= v.mask_cyc) mask_state = 1'b0;
         if (bus.rsp_valid || cyc >= 200) break;
         step();
         cyc++;
      end
      mask_state = 1'b0;
      check($sformatf("%s_latency", tag), 32'(cyc), 32'(v.exp_lat));
      check($sformatf("%s_rsp_data", tag), 32'(bus.rsp_data), 32'(v.exp_data));
      check($sformatf("%s_rsp_error", tag), 32'(bus.rsp_error), 32'(v.exp_err));
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      corrupt       = 1'b0;
      if (v.exp_err && exp_ec < 255) exp_ec++;
      check($sformatf("%s_err_count", tag), 32'(err_count), 32'(exp_ec));
   endtask

   vec_t          vecs [9];
   vec_t          sv;
   logic [1:0]    exp_in [8];
   logic [1:0]    exp_st [8];
   logic          saw_rsp;
   int            n;

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      vecs[0] = '{8'hA5, 1'b0, 0,    8,  8'hA5, 1'b0};
      vecs[1] = '{8'h00, 1'b0, 0,    8,  8'h00, 1'b0};
      vecs[2] = '{8'hFF, 1'b0, 0,    8,  8'hFF, 1'b0};
      vecs[3] = '{8'hA5, 1'b1, 0,    8,  8'h5A, 1'b1};
      vecs[4] = '{8'h3C, 1'b0, 1000, 16, 8'h00, 1'b1};
      vecs[5] = '{8'h81, 1'b0, 15,   22, 8'h81, 1'b0};
      vecs[6] = '{8'h81, 1'b0, 16,   16, 8'h00, 1'b1};
      vecs[7] = '{8'h01, 1'b1, 0,    8,  8'hFE, 1'b1};
      vecs[8] = '{8'hC3, 1'b0, 2,    9,  8'hC3, 1'b0};
      exp_in = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00};
      exp_st = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00};

      bus.req_valid = 1'b0;
      bus.req_data  = '0;
      bus.rsp_ready = 1'b0;

      // reset held for three cycles
      reset_n = 1'b0;
      repeat (3) step();
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      check("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
      check("rst_fsm_enable", 32'(fsm_enable), 32'd0);
      check("rst_fsm_input", 32'(fsm_input), 32'd0);
      check("rst_fsm_data", 32'(fsm_data), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      reset_n = 1'b1;
      check("release_req_ready_before_edge", 32'(bus.req_ready), 32'd0);
      step();
      check("release_req_ready", 32'(bus.req_ready), 32'd1);

      // nominal A5, cycle by cycle
      send(8'hA5);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("nom_fsm_input_c%0d", k), 32'(fsm_input), 32'(exp_in[k]));
         check($sformatf("nom_fsm_state_c%0d", k), 32'(fsm_state), 32'(exp_st[k]));
         check($sformatf("nom_fsm_enable_c%0d", k), 32'(fsm_enable), 32'd1);
         check($sformatf("nom_rsp_valid_c%0d", k), 32'(bus.rsp_valid), 32'd0);
         step();
      end
      check("nom_fsm_data", 32'(fsm_data), 32'hA5);
      check("nom_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("nom_rsp_data", 32'(bus.rsp_data), 32'hA5);
      check("nom_rsp_error", 32'(bus.rsp_error), 32'd0);
      check("nom_resp_enable", 32'(fsm_enable), 32'd0);
      check("nom_resp_input", 32'(fsm_input), 32'd0);
      check("nom_err_count", 32'(err_count), 32'd0);

      // backpressure with a competing request that must be ignored
      bus.req_valid = 1'b1;
      bus.req_data  = 8'h3C;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp_rsp_valid_c%0d", k), 32'(bus.rsp_valid), 32'd1);
         check($sformatf("bp_rsp_data_c%0d", k), 32'(bus.rsp_data), 32'hA5);
         check($sformatf("bp_req_ready_c%0d", k), 32'(bus.req_ready), 32'd0);
         step();
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      check("bp_after_hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("bp_after_hs_req_ready", 32'(bus.req_ready), 32'd1);
      sv = '{8'h3C, 1'b0, 0, 8, 8'h3C, 1'b0};
      run_txn(sv, "bp_3c");

      // table of transactions
      for (int i = 0; i < 9; i++) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
      end

      // error counter saturation
      for (int i = 0; i < 252; i++) begin
         sv = '{8'(i), 1'b1, 0, 8, ~8'(i), 1'b1};
         run_txn(sv, $sformatf("sat%0d", i));
      end
      check("err_count_saturated", 32'(err_count), 32'd255);

      // reset while fsm_input is WAIT
      send(8'hA5);
      n = 0;
      while (fsm_input != CMD_WAIT && n < 20) begin
         step();
         n++;
      end
      check("midwait_reached", 32'(fsm_input), 32'(CMD_WAIT));
      reset_n = 1'b0;
      step();
      check("midwait_fsm_enable", 32'(fsm_enable), 32'd0);
      check("midwait_fsm_input", 32'(fsm_input), 32'd0);
      check("midwait_fsm_data", 32'(fsm_data), 32'd0);
      check("midwait_req_ready", 32'(bus.req_ready), 32'd0);
      check("midwait_err_count", 32'(err_count), 32'd0);
      exp_ec  = 0;
      reset_n = 1'b1;
      saw_rsp = 1'b0;
      for (int k = 0; k < 30; k++) begin
         step();
         if (bus.rsp_valid) saw_rsp = 1'b1;
      end
      check("midwait_no_response", 32'(saw_rsp), 32'd0);
      check("midwait_req_ready_back", 32'(bus.req_ready), 32'd1);
      sv = '{8'h5A, 1'b0, 0, 8, 8'h5A, 1'b0};
      run_txn(sv, "post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
